// File: rtl/textconsole_writer.sv
// textconsole_writer: byte-stream terminal front end writing the text RAM via bufaddr/bufdata/bufwe.
// Define TEXTCON_CURSOR_EN to expose the registered cursor on cursor_col/cursor_row.
module textconsole_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        bufclk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [11:0] bufaddr,
  output logic [7:0]  bufdata,
  output logic        bufwe,
  output logic        busy
`ifdef TEXTCON_CURSOR_EN
  ,
  output logic [5:0]  cursor_col,
  output logic [5:0]  cursor_row
`endif
);
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;
  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
  state_t      state_q, state_d;
  logic [5:0]  row_q, row_d, col_q, col_d;
  logic [5:0]  crow_q, crow_d, ccol_q, ccol_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d, rdy_q, rdy_d;
  logic        xfer, printable, newline;
  logic [5:0]  row_inc;
  logic [6:0]  tab;
  assign xfer      = in_valid && rdy_q;
  assign printable = (in_data >= 8'h20) && (in_data != 8'h7F);
  assign row_inc   = (row_q == ROW_MAX) ? 6'd0 : row_q + 6'd1;
  assign tab       = {1'b0, col_q | 6'd7} + 7'd1;
  assign newline   = (in_data == 8'h0A) || (in_data == 8'h09 && tab >= 7'(COLS));
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        if (printable) begin
          we_d   = 1'b1;
          addr_d = {row_q, col_q};
          data_d = in_data;
          col_d  = (col_q == COL_MAX) ? 6'd0 : col_q + 6'd1;
          if (col_q == COL_MAX) begin
            row_d   = row_inc;
            crow_d  = row_inc;
            ccol_d  = 6'd0;
            state_d = CLR_LINE;
          end
        end else if (newline) begin
          col_d   = 6'd0;
          row_d   = row_inc;
          crow_d  = row_inc;
          ccol_d  = 6'd0;
          state_d = CLR_LINE;
        end else if (in_data == 8'h0D) begin
          col_d = 6'd0;
        end else if (in_data == 8'h08 && col_q != 6'd0) begin
          col_d  = col_q - 6'd1;
          we_d   = 1'b1;
          addr_d = {row_q, col_q - 6'd1};
          data_d = 8'h20;
        end else if (in_data == 8'h09) begin
          col_d = tab[5:0];
        end else if (in_data == 8'h0C) begin
          row_d   = 6'd0;
          col_d   = 6'd0;
          crow_d  = 6'd0;
          ccol_d  = 6'd0;
          state_d = CLR_SCREEN;
        end
      end
      default: begin
        // Both clear bursts walk the same counter; only the end condition differs.
        we_d   = 1'b1;
        addr_d = {crow_q, ccol_q};
        data_d = 8'h20;
        if (ccol_q != COL_MAX) begin
          ccol_d = ccol_q + 6'd1;
        end else if (state_q == CLR_LINE || crow_q == ROW_MAX) begin
          state_d = IDLE;
        end else begin
          ccol_d = 6'd0;
          crow_d = crow_q + 6'd1;
        end
      end
    endcase
    // Ready drops with the accepting edge but rises only a cycle after the last burst write.
    rdy_d = (state_q == IDLE) && (state_d == IDLE);
  end
  always_ff @(posedge bufclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_SCREEN;
      row_q   <= 6'd0;
      col_q   <= 6'd0;
      crow_q  <= 6'd0;
      ccol_q  <= 6'd0;
      addr_q  <= 12'd0;
      data_q  <= 8'd0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
    end
  end
  assign in_ready = rdy_q;
  assign busy     = !rdy_q;
  assign bufaddr  = addr_q;
  assign bufdata  = data_q;
  assign bufwe    = we_q;
`ifdef TEXTCON_CURSOR_EN
  assign cursor_col = col_q;
  assign cursor_row = row_q;
`endif
endmodule

// File: tb/tb_textconsole_writer.sv
// tb_textconsole_writer: table vectors, corner sequences and random bytes checked against a cursor/screen model.
module tb_textconsole_writer;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  logic        bufclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, bufwe, busy;
  logic [11:0] bufaddr;
  logic [7:0]  bufdata;
  textconsole_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .bufclk(bufclk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bufaddr(bufaddr), .bufdata(bufdata), .bufwe(bufwe), .busy(busy)
  );
  always #5 bufclk = ~bufclk;
  typedef struct packed {int t; logic [11:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [7:0] ch; int nw; logic [11:0] a; logic [7:0] d;} vec_t;
  wr_t  got[$], exp_q[$];
  vec_t tbl[18];
  int   cyc = 0, n_chk = 0, n_fail = 0, mr = 0, mc = 0;
  function automatic wr_t mk(int t, logic [11:0] a, logic [7:0] d);
    wr_t w;
    w.t = t;
    w.a = a;
    w.d = d;
    return w;
  endfunction
  always @(posedge bufclk) cyc <= cyc + 1;
  always @(negedge bufclk) if (bufwe === 1'b1) got.push_back(mk(cyc, bufaddr, bufdata));
  task automatic check(input string nm, input int act, input int want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, want, want);
    end
  endtask
  // Reference model: cursor arithmetic and the expected write stream tagged with its cycle.
  function automatic void push(int t, int r, int c, logic [7:0] d);
    exp_q.push_back(mk(t, 12'(r * 64 + c), d));
  endfunction
  function automatic void clr_line(int r, int n);
    for (int c = 0; c < COLS; c++) push(n + 1 + c, r, c, 8'h20);
  endfunction
  function automatic void clr_screen(int n);
    mr = 0;
    mc = 0;
    for (int i = 0; i < ROWS * COLS; i++) push(n + 1 + i, i / COLS, i % COLS, 8'h20);
  endfunction
  function automatic void newline(int n);
    mc = 0;
    mr = (mr + 1) % ROWS;
    clr_line(mr, n);
  endfunction
  function automatic void model(logic [7:0] b, int n);
    if (b >= 8'h20 && b != 8'h7F) begin
      push(n, mr, mc, b);
      mc++;
      if (mc == COLS) newline(n);
    end else if (b == 8'h0A) newline(n);
    else if (b == 8'h0D) mc = 0;
    else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        push(n, mr, mc, 8'h20);
      end
    end else if (b == 8'h09) begin
      if ((mc | 7) + 1 >= COLS) newline(n);
      else mc = (mc | 7) + 1;
    end else if (b == 8'h0C) clr_screen(n);
  endfunction
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 5000) begin
      @(posedge bufclk); #1;
      n++;
    end
    if (n >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed low for %0d cycles, want high", n);
      in_valid = 1'b0;
    end else begin
      @(posedge bufclk); #1;
      in_valid = 1'b0;
      model(b, cyc);
    end
  endtask
  task automatic drain();
    int n = 0;
    @(posedge bufclk); #1;
    while (in_ready !== 1'b1 && n < 5000) begin
      @(posedge bufclk); #1;
      n++;
    end
    if (n >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: in_ready stayed low for %0d cycles, want high", n);
    end
  endtask
  task automatic compare_model(input string nm);
    check({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_write[%0d]: got cyc=%0d addr=%h data=%h, want cyc=%0d addr=%h data=%h",
                 nm, i, got[i].t, got[i].a, got[i].d, exp_q[i].t, exp_q[i].a, exp_q[i].d);
        break;
      end
    end
    got.delete();
    exp_q.delete();
  endtask
  task automatic release_and_check(input string nm);
    int z = 0, bad = 0;
    rst_n = 1'b1;
    clr_screen(cyc);
    for (int k = 0; k < ROWS * COLS; k++) begin
      @(posedge bufclk); #1;
      if (in_ready === 1'b0) z++;
    end
    check({nm, "_ready_low_cycles"}, z, ROWS * COLS);
    @(posedge bufclk); #1;
    check({nm, "_ready_after"}, in_ready, 1);
    check({nm, "_writes"}, got.size(), ROWS * COLS);
    foreach (got[i]) if (got[i].a[5:0] >= COLS || got[i].d != 8'h20) bad++;
    check({nm, "_bad_cells"}, bad, 0);
    compare_model(nm);
    send(8'h51);
    drain();
    check({nm, "_home_addr"}, got.size() > 0 ? int'(got[0].a) : -1, 12'h000);
    compare_model({nm, "_home"});
  endtask
  initial begin
    int base;
    int ncy;
    int r;
    int v;
    logic [7:0] b;
    tbl[0]  = '{8'h41, 1, 12'h000, 8'h41};
    tbl[1]  = '{8'h42, 1, 12'h001, 8'h42};
    tbl[2]  = '{8'h00, 0, 12'h000, 8'h00};
    tbl[3]  = '{8'h7F, 0, 12'h000, 8'h00};
    tbl[4]  = '{8'h80, 1, 12'h002, 8'h80};
    tbl[5]  = '{8'h43, 1, 12'h003, 8'h43};
    tbl[6]  = '{8'h44, 1, 12'h004, 8'h44};
    tbl[7]  = '{8'h08, 1, 12'h004, 8'h20};
    tbl[8]  = '{8'h0D, 0, 12'h000, 8'h00};
    tbl[9]  = '{8'h08, 0, 12'h000, 8'h00};
    tbl[10] = '{8'h09, 0, 12'h000, 8'h00};
    tbl[11] = '{8'h45, 1, 12'h008, 8'h45};
    tbl[12] = '{8'h0A, 40, 12'h040, 8'h20};
    tbl[13] = '{8'hFF, 1, 12'h040, 8'hFF};
    tbl[14] = '{8'h7E, 1, 12'h041, 8'h7E};
    tbl[15] = '{8'h1B, 0, 12'h000, 8'h00};
    tbl[16] = '{8'h0C, 1200, 12'h000, 8'h20};
    tbl[17] = '{8'h7A, 1, 12'h000, 8'h7A};
    repeat (3) @(posedge bufclk);
    #1;
    check("rst_bufwe", bufwe, 0);
    check("rst_bufaddr", bufaddr, 0);
    check("rst_bufdata", bufdata, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    release_and_check("scr0");
    send(8'h0D);
    drain();
    compare_model("cr");
    send(8'h41);
    check("ab_ready_held", in_ready, 1);
    send(8'h42);
    drain();
    check("ab_gap", got.size() >= 2 ? got[1].t - got[0].t : -1, 1);
    check("ab_addr0", got.size() >= 2 ? int'(got[0].a) : -1, 12'h000);
    check("ab_addr1", got.size() >= 2 ? int'(got[1].a) : -1, 12'h001);
    compare_model("ab");
    send(8'h0D);
    drain();
    compare_model("cr2");
    for (int i = 0; i < 18; i++) begin
      base = got.size();
      send(tbl[i].ch);
      drain();
      check($sformatf("tbl%0d_nw", i), got.size() - base, tbl[i].nw);
      if (tbl[i].nw > 0) begin
        check($sformatf("tbl%0d_addr", i), got.size() > base ? int'(got[base].a) : -1, tbl[i].a);
        check($sformatf("tbl%0d_data", i), got.size() > base ? int'(got[base].d) : -1, tbl[i].d);
      end
    end
    compare_model("table");
    send(8'h0D);
    drain();
    compare_model("cr3");
    for (int i = 0; i < COLS; i++) send(8'h78);
    check("wrap_ready_drop", in_ready, 0);
    ncy = 0;
    while (in_ready !== 1'b1 && ncy < 5000) begin
      @(posedge bufclk); #1;
      ncy++;
    end
    check("wrap_ready_cycles", ncy, COLS + 1);
    check("wrap_nw", got.size(), 2 * COLS);
    check("wrap_last_char", got.size() >= 80 ? int'(got[39].a) : -1, 12'h027);
    check("wrap_clr_first", got.size() >= 80 ? int'(got[40].a) : -1, 12'h040);
    check("wrap_clr_last", got.size() >= 80 ? int'(got[79].a) : -1, 12'h067);
    compare_model("wrap");
    for (int i = 0; i < 28; i++) send(8'h0A);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    drain();
    compare_model("rows");
    send(8'h0A);
    drain();
    check("rowwrap_nw", got.size(), COLS);
    check("rowwrap_first", got.size() > 0 ? int'(got[0].a) : -1, 12'h000);
    check("rowwrap_last", got.size() >= COLS ? int'(got[COLS-1].a) : -1, 12'h027);
    compare_model("rowwrap");
    for (int i = 0; i < 4; i++) send(8'h09);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    drain();
    compare_model("tabs");
    send(8'h09);
    drain();
    check("tab_lf_nw", got.size(), COLS);
    check("tab_lf_first", got.size() > 0 ? int'(got[0].a) : -1, 12'h040);
    compare_model("tab_lf");
    send(8'h0A);
    repeat (10) @(posedge bufclk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_bufwe", bufwe, 0);
    check("abort_busy", busy, 1);
    check("abort_partial_writes", got.size(), 9);
    got.delete();
    exp_q.delete();
    @(posedge bufclk); #1;
    release_and_check("scr1");
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 199));
      v = int'($urandom_range(0, 222));
      if (r < 140) b = (v < 95) ? 8'(32 + v) : 8'(128 + v - 95);
      else if (r < 152) b = 8'h0A;
      else if (r < 162) b = 8'h0D;
      else if (r < 177) b = 8'h08;
      else if (r < 189) b = 8'h09;
      else if (r < 190) b = 8'h0C;
      else b = (v % 4 == 0) ? 8'h00 : (v % 4 == 1) ? 8'h1B : (v % 4 == 2) ? 8'h7F : 8'h0B;
      send(b);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge bufclk); #1;
      end
    end
    drain();
    compare_model("random");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/textconsole_writer.md
Name: textconsole_writer

Overview:
- Byte-stream terminal front end that writes the text RAM of the text display block through its bufclk/bufaddr/bufdata/bufwe write port.
- Takes ASCII characters over a valid/ready stream from a CPU bridge or UART and keeps a cursor.
- Interprets a small set of control codes and clears lines and the screen by generating write bursts.
- Text RAM address is {row[5:0], col[5:0]}; stride is 64 cells per row regardless of visible width.

Parameters:
COLS, 40, visible columns (1..64)
ROWS, 30, visible rows (1..64)

Ports:
bufclk  in  1  clock; also the text RAM write clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  character available
in_data  in  8  character byte
in_ready  out  1  block can accept a character this cycle
bufaddr  out  12  text RAM write address {row, col}
bufdata  out  8  text RAM write data
bufwe  out  1  text RAM write enable
busy  out  1  clear burst in progress

Behaviour:
- Clock and reset: one clock, bufclk. Reset rst_n is asynchronous and active-low. Every flop resets on the falling edge of rst_n.
- Reset values: bufwe=0, bufaddr=0, bufdata=0, in_ready=0, busy=1, cursor row=0 and col=0, state=CLR_SCREEN with the clear counter at (0,0).
- An assertion of rst_n mid-burst or mid-write aborts the operation immediately and restarts the full screen clear.
- States: IDLE, CLR_LINE, CLR_SCREEN.
- Signal relations:
  - in_ready = (state==IDLE), registered.
  - busy = !in_ready.
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - in_data is ignored when in_ready=0; the source must hold in_valid and in_data.
- All write outputs are registered. A transfer accepted at edge N drives its write (if any) during cycle N+1 (1-cycle latency). bufwe is high for exactly one cycle per write.
- In IDLE, one character is accepted per cycle back-to-back unless it causes a burst.
- Printable bytes (0x20..0x7E, 0x80..0xFF):
  - Write the byte at (row, col), then col++.
  - If col was COLS-1: col=0, row=(row+1) mod ROWS, enter CLR_LINE for the new row.
- 0x0A LF: col=0, row=(row+1) mod ROWS, enter CLR_LINE. No character is written.
- 0x0D CR: col=0. No write.
- 0x08 BS:
  - If col>0: col--, then write 0x20 at the new (row, col).
  - If col=0: no write and no cursor change. There is no reverse wrap.
- 0x09 TAB: col=(col|7)+1. If the result is >= COLS, behave as LF. No write.
- 0x0C FF: cursor to (0,0), enter CLR_SCREEN.
- Other bytes 0x00..0x1F and 0x7F: consumed, no effect.
- Row wrap: after row ROWS-1 the next row is 0. There is no scrolling; the newly entered line is always cleared.
- CLR_LINE:
  - Writes 0x20 to (row, 0..COLS-1) at one cell per cycle, ascending.
  - This takes exactly COLS write cycles with bufwe continuously high, then returns to IDLE.
  - in_ready rises the cycle after the last write.
- CLR_SCREEN:
  - Writes 0x20 to every visible cell, row-major, one per cycle: ROWS*COLS cycles (1200 at defaults).
  - Columns COLS..63 are never written; addresses skip directly from (r, COLS-1) to (r+1, 0).
  - Then goes to IDLE.
- Arithmetic: the column counter is 6 bits and the row counter is 6 bits. All comparisons are against COLS-1 and ROWS-1, never 63, so non-power-of-two geometry wraps correctly.
- A printable byte that wraps: its own write happens at (row, COLS-1), then the CLR_LINE burst begins on the following cycle with no gap.

Optional Feature:
- Macro: TEXTCON_CURSOR_EN.
- Defined: adds output ports cursor_col[5:0] and cursor_row[5:0], which reflect the registered cursor (reset 0,0). They update on the cycle after the transfer that changes them. A display overlay uses them to draw a cursor.
- Undefined: the ports are absent; the cursor is internal only. All other behaviour is identical.

Test Plan:
1. Reset release -> in_ready=0 for exactly 1200 cycles. Exactly 1200 writes of 0x20 occur, covering addr 0x000..0x027, 0x040..0x067, ..., 0x740..0x767, with no address having col>=40. in_ready=1 on the next cycle.
2. Stream "AB", back-to-back valid -> writes 0x41@0x000 then 0x42@0x001 on consecutive cycles; in_ready stays 1.
3. 40 x 'x' from (0,0) -> the 40th write is at 0x027. The next 40 cycles write 0x20 to 0x040..0x067 with in_ready=0. The cursor ends at (1,0).
4. Cursor (0,5), send 0x08 -> one write 0x20@0x004, cursor (0,4). Then CR, BS -> no write, cursor (0,0).
5. Cursor (29,3), send 0x0A -> cursor (0,0), and the clear burst writes addresses 0x000..0x027. Send 0x09 at col 35 -> behaves as LF.
6. Assert rst_n low during the 10th cycle of a CLR_LINE -> bufwe=0 immediately. After release, a full 1200-cycle screen clear runs and the cursor is (0,0).
